// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-detector state encoding and the default
// datapath widths also used by the PLL top level.
package adpll_pkg;

  localparam int LD_ERROR_WIDTH  = 8;
  localparam int LD_DCO_CC_WIDTH = 5;

  typedef enum logic [1:0] {
    LD_UNLOCKED  = 2'd0,
    LD_ACQUIRING = 2'd1,
    LD_LOCKED    = 2'd2,
    LD_SLIPPING  = 2'd3
  } ld_state_e;

  // SLIPPING still counts as locked: the loop has not yet been declared lost.
  function automatic logic ld_is_locked(input ld_state_e s);
    return (s == LD_LOCKED) || (s == LD_SLIPPING);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a registered
// rising-edge detector producing a one-cycle pulse in the clk_i domain.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/adpll_lock_detector.sv
// ADPLL lock monitor: evaluates phase error once per reference tick, qualifies
// lock with hysteresis, and flags reference loss and DCO code saturation.
module adpll_lock_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH  = LD_ERROR_WIDTH,
  parameter int DCO_CC_WIDTH = LD_DCO_CC_WIDTH,
  parameter int LOCK_TOL     = 2,
  parameter int UNLOCK_TOL   = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int RAIL_COUNT   = 8,
  parameter int REF_TIMEOUT  = 4096,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           fpga_clk_i,
  input  logic                           reset_i,
  input  logic                           ref_clk_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
  output logic                           locked_o,
  output logic [1:0]                     state_o,
  output logic                           unlock_event_o,
  output logic                           ref_lost_o,
  output logic                           dco_at_rail_o
);

  localparam int AW = ERROR_WIDTH + 1;

  localparam logic [AW-1:0]        LOCK_TOL_W   = AW'(LOCK_TOL);
  localparam logic [AW-1:0]        UNLOCK_TOL_W = AW'(UNLOCK_TOL);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
  localparam logic [CNT_WIDTH-1:0] LOCK_CNT_W   = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_CNT_W = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] RAIL_CNT_W   = CNT_WIDTH'(RAIL_COUNT);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST     = CNT_WIDTH'(REF_TIMEOUT - 1);

  localparam logic [DCO_CC_WIDTH-1:0] DCO_MAX = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
  localparam logic [DCO_CC_WIDTH-1:0] DCO_MIN = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

  ld_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]  tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  rail_cnt_q, rail_cnt_d;
  logic                  unlock_q, unlock_d;
  logic                  ref_lost_q, ref_lost_d;
  logic                  rail_q, rail_d;

  logic                  tick;
  logic                  timeout;
  logic signed [AW-1:0]  err_ext;
  logic [AW-1:0]         abs_err;
  logic                  in_lock;
  logic                  in_hold;
  logic                  at_rail;

  edge_sync u_ref_sync (
    .clk_i   (fpga_clk_i),
    .rst_i   (reset_i),
    .async_i (ref_clk_i),
    .pulse_o (tick)
  );

  // One extra bit so that the most negative error has a representable magnitude.
  always_comb begin
    err_ext = {error_i[ERROR_WIDTH-1], error_i};
    abs_err = err_ext[AW-1] ? -err_ext : err_ext;
    in_lock = (abs_err <= LOCK_TOL_W);
    in_hold = (abs_err <= UNLOCK_TOL_W);
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign at_rail = (dco_cc_i == DCO_MAX) || (dco_cc_i == DCO_MIN);

  always_comb begin
    tmo_d      = tmo_q;
    ref_lost_d = ref_lost_q;
    timeout    = 1'b0;
    if (tick) begin
      tmo_d      = CNT_ZERO;
      ref_lost_d = 1'b0;
    end else if (tmo_q >= TMO_LAST) begin
      tmo_d      = TMO_LAST;
      ref_lost_d = 1'b1;
      timeout    = 1'b1;
    end else begin
      tmo_d = tmo_q + CNT_ONE;
    end
  end

  always_comb begin
    rail_cnt_d = rail_cnt_q;
    if (tick) begin
      if (!at_rail) begin
        rail_cnt_d = CNT_ZERO;
      end else if (rail_cnt_q < RAIL_CNT_W) begin
        rail_cnt_d = rail_cnt_q + CNT_ONE;
      end
    end
    rail_d = (rail_cnt_d == RAIL_CNT_W);
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= LD_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // A tick always takes priority; the timeout only acts in tick-free cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    unlock_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        LD_UNLOCKED: begin
          if (in_lock) begin
            if (LOCK_COUNT == 1) begin
              state_d = LD_LOCKED;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = LD_ACQUIRING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        LD_ACQUIRING: begin
          if (in_lock) begin
            if (cnt_inc == LOCK_CNT_W) begin
              state_d = LD_LOCKED;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = LD_UNLOCKED;
            cnt_d   = CNT_ZERO;
          end
        end
        LD_LOCKED: begin
          if (!in_hold) begin
            if (UNLOCK_COUNT == 1) begin
              state_d  = LD_UNLOCKED;
              cnt_d    = CNT_ZERO;
              unlock_d = 1'b1;
            end else begin
              state_d = LD_SLIPPING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        LD_SLIPPING: begin
          if (in_hold) begin
            state_d = LD_LOCKED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_inc == UNLOCK_CNT_W) begin
            state_d  = LD_UNLOCKED;
            cnt_d    = CNT_ZERO;
            unlock_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = LD_UNLOCKED;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else if (timeout) begin
      state_d  = LD_UNLOCKED;
      cnt_d    = CNT_ZERO;
      unlock_d = ld_is_locked(state_q);
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      tmo_q      <= '0;
      rail_cnt_q <= '0;
      unlock_q   <= 1'b0;
      ref_lost_q <= 1'b0;
      rail_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      rail_cnt_q <= rail_cnt_d;
      unlock_q   <= unlock_d;
      ref_lost_q <= ref_lost_d;
      rail_q     <= rail_d;
    end
  end

  always_comb begin
    locked_o       = ld_is_locked(state_q);
    state_o        = state_q;
    unlock_event_o = unlock_q;
    ref_lost_o     = ref_lost_q;
    dco_at_rail_o  = rail_q;
  end

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Self-checking bench for adpll_lock_detector: a tick-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_adpll_lock_detector;

  localparam int EW           = 8;
  localparam int DW           = 5;
  localparam int LOCK_TOL     = 2;
  localparam int UNLOCK_TOL   = 4;
  localparam int LOCK_COUNT   = 16;
  localparam int UNLOCK_COUNT = 4;
  localparam int RAIL_COUNT   = 8;
  localparam int REF_TIMEOUT  = 4096;
  localparam int HALF_REF     = 50;

  logic                 fpga_clk_i = 1'b0;
  logic                 reset_i    = 1'b1;
  logic                 ref_clk_i  = 1'b0;
  logic signed [EW-1:0] error_i    = '0;
  logic signed [DW-1:0] dco_cc_i   = '0;
  logic                 locked_o;
  logic [1:0]           state_o;
  logic                 unlock_event_o;
  logic                 ref_lost_o;
  logic                 dco_at_rail_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_count  = 0;
  bit locked_seen  = 0;

  always #5 fpga_clk_i = ~fpga_clk_i;

  adpll_lock_detector #(
    .ERROR_WIDTH  (EW),
    .DCO_CC_WIDTH (DW),
    .LOCK_TOL     (LOCK_TOL),
    .UNLOCK_TOL   (UNLOCK_TOL),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT),
    .RAIL_COUNT   (RAIL_COUNT),
    .REF_TIMEOUT  (REF_TIMEOUT),
    .CNT_WIDTH    (16)
  ) dut (
    .fpga_clk_i     (fpga_clk_i),
    .reset_i        (reset_i),
    .ref_clk_i      (ref_clk_i),
    .error_i        (error_i),
    .dco_cc_i       (dco_cc_i),
    .locked_o       (locked_o),
    .state_o        (state_o),
    .unlock_event_o (unlock_event_o),
    .ref_lost_o     (ref_lost_o),
    .dco_at_rail_o  (dco_at_rail_o)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a ref level seen at one edge is acted on two edges later;
  // lock/slip are run lengths of good/bad ticks; timeout counts tick-free edges.
  int m_state = 0, m_run = 0, m_bad = 0, m_since = 0, m_rail_run = 0;
  bit m_lost = 0, m_unlock = 0, m_rail = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  always @(posedge fpga_clk_i or posedge reset_i) begin : model_step
    bit t;
    int e, a, d;
    if (reset_i) begin
      m_state = 0; m_run = 0; m_bad = 0; m_since = 0; m_rail_run = 0;
      m_lost = 0; m_unlock = 0; m_rail = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      t  = h2 && !h3;
      h3 = h2; h2 = h1; h1 = ref_clk_i;
      m_unlock = 0;
      e = int'(error_i);
      a = (e < 0) ? -e : e;
      d = int'(dco_cc_i);
      if (t) begin
        m_since = 0;
        m_lost  = 0;
        if (m_state <= 1) begin
          if (a <= LOCK_TOL) begin
            m_run++;
            if (m_run >= LOCK_COUNT) begin m_state = 2; m_run = 0; end
            else m_state = 1;
          end else begin
            m_run = 0; m_state = 0;
          end
        end else begin
          if (a <= UNLOCK_TOL) begin
            m_bad = 0; m_state = 2;
          end else begin
            m_bad++;
            if (m_bad >= UNLOCK_COUNT) begin
              m_state = 0; m_bad = 0; m_run = 0; m_unlock = 1;
            end else m_state = 3;
          end
        end
        if (d == (1 << (DW-1)) - 1 || d == -(1 << (DW-1)))
          m_rail_run = (m_rail_run < RAIL_COUNT) ? m_rail_run + 1 : RAIL_COUNT;
        else
          m_rail_run = 0;
        m_rail = (m_rail_run == RAIL_COUNT);
      end else begin
        if (m_since < REF_TIMEOUT) m_since++;
        if (m_since >= REF_TIMEOUT) begin
          m_lost = 1;
          if (m_state >= 2) m_unlock = 1;
          m_state = 0; m_run = 0; m_bad = 0;
        end
      end
    end
  end

  always @(negedge fpga_clk_i) begin
    checkOutput("model_state",    int'(state_o),        m_state);
    checkOutput("model_locked",   int'(locked_o),       (m_state >= 2) ? 1 : 0);
    checkOutput("model_unlock",   int'(unlock_event_o), int'(m_unlock));
    checkOutput("model_ref_lost", int'(ref_lost_o),     int'(m_lost));
    checkOutput("model_rail",     int'(dco_at_rail_o),  int'(m_rail));
    if (unlock_event_o) pulse_count++;
    if (locked_o) locked_seen = 1;
  end

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge fpga_clk_i);
  endtask

  // One full 1 MHz reference period with the given error and control code held.
  task automatic applyStimulus(input int err, input int dco);
    @(negedge fpga_clk_i);
    error_i   = EW'(err);
    dco_cc_i  = DW'(dco);
    ref_clk_i = 1'b1;
    waitCycles(HALF_REF);
    ref_clk_i = 1'b0;
    waitCycles(HALF_REF - 1);
  endtask

  initial begin
    waitCycles(3);
    checkOutput("reset_state",    int'(state_o),        0);
    checkOutput("reset_locked",   int'(locked_o),       0);
    checkOutput("reset_unlock",   int'(unlock_event_o), 0);
    checkOutput("reset_ref_lost", int'(ref_lost_o),     0);
    checkOutput("reset_rail",     int'(dco_at_rail_o),  0);
    reset_i = 1'b0;
    waitCycles(2);

    applyStimulus(1, 0);
    checkOutput("acq_state_1", int'(state_o), 1);
    for (int i = 2; i <= 15; i++) applyStimulus(1, 0);
    checkOutput("acq_state_15",  int'(state_o),  1);
    checkOutput("acq_locked_15", int'(locked_o), 0);
    applyStimulus(1, 0);
    checkOutput("acq_state_16",  int'(state_o),  2);
    checkOutput("acq_locked_16", int'(locked_o), 1);
    applyStimulus(1, 0);
    checkOutput("acq_state_17", int'(state_o), 2);

    for (int i = 0; i < 10; i++) applyStimulus(3, 0);
    checkOutput("hold_err3_state", int'(state_o), 2);
    for (int i = 0; i < 3; i++) applyStimulus(-5, 0);
    checkOutput("slip_state", int'(state_o), 3);
    checkOutput("slip_locked", int'(locked_o), 1);
    applyStimulus(0, 0);
    checkOutput("slip_recover_state", int'(state_o), 2);

    pulse_count = 0;
    for (int i = 0; i < 3; i++) applyStimulus(-128, 0);
    checkOutput("min_err_slip_state", int'(state_o), 3);
    applyStimulus(-128, 0);
    checkOutput("min_err_unlock_state", int'(state_o), 0);
    checkOutput("min_err_pulse_count", pulse_count, 1);

    locked_seen = 0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 0);
    checkOutput("abort_acq_state", int'(state_o), 1);
    applyStimulus(3, 0);
    checkOutput("abort_state", int'(state_o), 0);
    checkOutput("abort_never_locked", int'(locked_seen), 0);

    for (int i = 0; i < LOCK_COUNT; i++) applyStimulus(0, 0);
    checkOutput("relock_state", int'(state_o), 2);
    pulse_count = 0;
    waitCycles(REF_TIMEOUT - 200);
    checkOutput("pre_timeout_ref_lost", int'(ref_lost_o), 0);
    waitCycles(400);
    checkOutput("timeout_ref_lost", int'(ref_lost_o), 1);
    checkOutput("timeout_state", int'(state_o), 0);
    checkOutput("timeout_pulse_count", pulse_count, 1);
    applyStimulus(0, 0);
    checkOutput("restart_ref_lost", int'(ref_lost_o), 0);
    checkOutput("restart_state", int'(state_o), 1);

    for (int i = 0; i < RAIL_COUNT - 1; i++) applyStimulus(0, 15);
    checkOutput("rail_before", int'(dco_at_rail_o), 0);
    applyStimulus(0, 15);
    checkOutput("rail_set", int'(dco_at_rail_o), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, -16);
      applyStimulus(0, 15);
    end
    checkOutput("rail_alternate", int'(dco_at_rail_o), 1);
    applyStimulus(0, 3);
    checkOutput("rail_clear", int'(dco_at_rail_o), 0);

    waitCycles(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adpll_lock_detector.md
Name: adpll_lock_detector

Overview:
- Downstream monitor for the ring-oscillator ADPLL.
- Consumes the signed phase error and the DCO control code produced by the PLL top level, and samples them once per reference period.
- Qualifies lock with hysteresis and flags loss of reference and DCO control-code saturation.
- Runs entirely in the fpga_clk_i domain; feeds status LEDs and the debug readout.

Parameters:
- ERROR_WIDTH, 8: width of signed error_i.
- DCO_CC_WIDTH, 5: width of signed dco_cc_i.
- LOCK_TOL, 2: max |error| counted as in-window for acquisition.
- UNLOCK_TOL, 4: max |error| tolerated while locked. Must satisfy UNLOCK_TOL >= LOCK_TOL.
- LOCK_COUNT, 16: consecutive in-window evaluations required to declare lock (>= 1).
- UNLOCK_COUNT, 4: consecutive out-of-window evaluations required to drop lock (>= 1).
- RAIL_COUNT, 8: consecutive evaluations with dco_cc_i at min or max before the rail flag asserts.
- REF_TIMEOUT, 4096: fpga_clk_i cycles without a reference tick before ref_lost_o asserts.
- CNT_WIDTH, 16: width of the internal counters. Must hold REF_TIMEOUT, LOCK_COUNT and RAIL_COUNT.

Ports:
- fpga_clk_i  in  1  system clock; all logic is on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- ref_clk_i  in  1  reference clock, asynchronous to fpga_clk_i.
- error_i  in  ERROR_WIDTH  signed phase error in fpga clock cycles.
- dco_cc_i  in  DCO_CC_WIDTH  signed DCO control code from the loop filter.
- locked_o  out  1  high in LOCKED or SLIPPING.
- state_o  out  2  encoding: 0 = UNLOCKED, 1 = ACQUIRING, 2 = LOCKED, 3 = SLIPPING.
- unlock_event_o  out  1  one-cycle pulse on any transition from LOCKED or SLIPPING to UNLOCKED.
- ref_lost_o  out  1  reference timeout flag.
- dco_at_rail_o  out  1  DCO control code saturated.

Behaviour:
- Reset: one clock, fpga_clk_i. reset_i is asynchronous and active-high.
  - All outputs go to 0. State goes to UNLOCKED.
  - All counters and synchroniser flops clear.
- Reference tick generation:
  - ref_clk_i passes through a 2-flop synchroniser, then a registered edge detector.
  - tick is a one-cycle pulse on each synchronised rising edge.
  - A ref_clk_i rising edge affects the outputs 3 to 4 fpga_clk_i edges later.
- Evaluation on a tick cycle:
  - error_i and dco_cc_i are sampled in the tick cycle.
  - State, counters and outputs update on the clock edge that ends the tick cycle.
- Magnitude: abs_err is computed at ERROR_WIDTH+1 bits, so the most negative error (-128) yields 128 with no wrap.
- Window tests: in_lock = abs_err <= LOCK_TOL; in_hold = abs_err <= UNLOCK_TOL.
- FSM; each transition below happens on a tick only:
  - UNLOCKED:
    - in_lock: cnt = 1, go to ACQUIRING. If LOCK_COUNT == 1, go straight to LOCKED instead.
    - otherwise: stay.
  - ACQUIRING:
    - in_lock: cnt increments; when cnt reaches LOCK_COUNT, go to LOCKED.
    - otherwise: cnt = 0, go to UNLOCKED.
  - LOCKED:
    - in_hold: stay.
    - otherwise: cnt = 1, go to SLIPPING. If UNLOCK_COUNT == 1, go to UNLOCKED and pulse unlock_event_o instead.
  - SLIPPING:
    - in_hold: cnt = 0, go to LOCKED.
    - otherwise: cnt increments; when cnt reaches UNLOCK_COUNT, go to UNLOCKED and pulse unlock_event_o.
- Reference timeout:
  - tmo counts fpga_clk_i cycles and clears on every tick.
  - When tmo reaches REF_TIMEOUT-1 with no tick:
    - ref_lost_o goes to 1 and the FSM is forced to UNLOCKED.
    - cnt clears.
    - unlock_event_o pulses if the FSM was in LOCKED or SLIPPING.
    - tmo saturates.
  - The next tick clears ref_lost_o and is evaluated normally in the same cycle.
  - If the timeout and a tick coincide, the tick wins.
- Rail detect:
  - On each tick, if dco_cc_i equals the signed max or signed min, rail_cnt increments, saturating at RAIL_COUNT. Otherwise rail_cnt = 0.
  - dco_at_rail_o = (rail_cnt == RAIL_COUNT), registered.
  - The rail flag is independent of the FSM.
- Counter limits: all counters saturate and never wrap.
- Reset mid-operation: asynchronous return to reset values; no pulse is emitted on reset.

Decomposition:
- Shared package adpll_pkg holds:
  - state encoding constants LD_UNLOCKED, LD_ACQUIRING, LD_LOCKED, LD_SLIPPING;
  - the default ERROR_WIDTH and DCO_CC_WIDTH, shared with the PLL top level.
- One natural sub-module: edge_sync (2-flop synchroniser plus rising-edge pulse, asynchronous reset), reusable for ref_clk_i elsewhere.

Test Plan:
- Reset check: reset_i = 1, 100 MHz fpga clock, 1 MHz ref_clk_i, error_i = 0 -> all outputs 0 and state_o = 0 while reset_i is high.
- Acquisition: error_i = 1 held, 17 reference edges with default parameters -> state_o steps 0 -> 1 -> 2; locked_o rises after the 16th evaluated tick.
- Hysteresis and loss of lock:
  - While LOCKED, error_i = 3 for 10 ticks -> state stays 2.
  - Then error_i = -5 for 3 ticks followed by 0 -> state 3, then back to 2.
  - Then error_i = -128 for 4 ticks -> state 0; unlock_event_o is high for exactly one cycle; abs = 128 is handled with no wrap.
- Acquisition abort: error_i = 0 for 10 ticks, then 3 for 1 tick -> state returns from 1 to 0 with locked_o never asserted.
- Reference loss: while LOCKED, stop ref_clk_i -> after 4096 cycles ref_lost_o = 1, state 0, one unlock_event_o pulse. Restart ref_clk_i -> ref_lost_o clears on the first tick.
- Rail detect:
  - dco_cc_i = 15 for 8 ticks -> dco_at_rail_o = 1.
  - dco_cc_i = -16 alternating with 15 -> flag stays 1.
  - dco_cc_i = 3 -> flag clears on that tick.
